// File: rtl/mlkem_top_modmul_pipe.sv
// Three-stage signed x unsigned multiplier with optional exact Barrett reduction mod Q.
// Latency 3 cycles; the whole pipe freezes while a result is held and out_ready is low.
module mlkem_top_modmul_pipe #(
  parameter int DIN0_WIDTH = 16,
  parameter int DIN1_WIDTH = 13,
  parameter int DOUT_WIDTH = 29,
  parameter int Q          = 3329,
  parameter int K          = 40,
  parameter int TAG_WIDTH  = 8
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  input  logic                  mode,
  input  logic [TAG_WIDTH-1:0]  tag_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic [TAG_WIDTH-1:0]  tag_out
);

  localparam int TW = DOUT_WIDTH + 1;
  localparam int PW = DOUT_WIDTH + K + 2;
  localparam int EW = DOUT_WIDTH + 2;
  localparam logic [K:0] ONE_K = {1'b1, {K{1'b0}}};
  localparam logic [K:0] QW    = (K+1)'(Q);
  localparam logic [K:0] M     = ONE_K / QW;
  localparam logic signed [EW-1:0] QE = EW'(Q);

  logic advance;
  logic take;

  logic                         s1_vld, s2_vld;
  logic                         s1_mode, s2_mode;
  logic [TAG_WIDTH-1:0]         s1_tag, s2_tag;
  logic signed [DOUT_WIDTH-1:0] s1_p, s2_p;
  logic signed [TW-1:0]         s2_t;

  logic signed [DOUT_WIDTH-1:0] p_comb;
  logic signed [PW-1:0]         prod;
  logic signed [TW-1:0]         t_comb;
  logic signed [EW-1:0]         r0, r1, r2;
  logic [DOUT_WIDTH-1:0]        res;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign take     = in_valid && advance;

  // Zero-extending din1 by one bit keeps it non-negative in the signed product.
  assign p_comb = DOUT_WIDTH'($signed(din0)) * DOUT_WIDTH'($signed({1'b0, din1}));

  assign prod   = PW'(s1_p) * PW'($signed({1'b0, M}));
  assign t_comb = TW'(prod >>> K);

  // The quotient estimate is off by at most one, so r0 lies in [-Q, 2Q);
  // modular wrap in EW bits is harmless because the true value is small.
  always_comb begin
    r0  = EW'(s2_p) - EW'(s2_t) * QE;
    r1  = (r0 < 0) ? r0 + QE : r0;
    r2  = (r1 >= QE) ? r1 - QE : r1;
    res = DOUT_WIDTH'(s2_p);
    if (s2_mode) begin
      res = {{(DOUT_WIDTH-DIN1_WIDTH){1'b0}}, r2[DIN1_WIDTH-1:0]};
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      s1_vld    <= 1'b0;
      s1_mode   <= 1'b0;
      s1_tag    <= '0;
      s1_p      <= '0;
      s2_vld    <= 1'b0;
      s2_mode   <= 1'b0;
      s2_tag    <= '0;
      s2_p      <= '0;
      s2_t      <= '0;
      out_valid <= 1'b0;
      dout      <= '0;
      tag_out   <= '0;
    end else if (advance) begin
      s1_vld    <= take;
      s1_mode   <= mode;
      s1_tag    <= tag_in;
      s1_p      <= p_comb;
      s2_vld    <= s1_vld;
      s2_mode   <= s1_mode;
      s2_tag    <= s1_tag;
      s2_p      <= s1_p;
      s2_t      <= t_comb;
      out_valid <= s2_vld;
      dout      <= res;
      tag_out   <= s2_tag;
    end
  end

endmodule
